// File: rtl/clint_pkg.sv
// Shared constants for the CLINT-style timer: register map, CTRL field layout
// and reset values.
package clint_pkg;

  localparam int unsigned ADDR_MTIME_LO = 0;
  localparam int unsigned ADDR_MTIME_HI = 1;
  localparam int unsigned ADDR_CTRL     = 2;
  localparam int unsigned ADDR_MSIP     = 3;
  localparam int unsigned ADDR_CMP_BASE = 4;

  localparam int unsigned CTRL_EN_BIT  = 0;
  localparam int unsigned CTRL_DIV_LSB = 8;

  localparam logic [63:0] MTIMECMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF;

  // Word address of the LO (hi=0) or HI (hi=1) half of a hart's mtimecmp
  function automatic int unsigned cmp_addr(input int unsigned hart, input logic hi);
    return ADDR_CMP_BASE + 2 * hart + (hi ? 1 : 0);
  endfunction

endpackage

// File: rtl/clint_timer_tick_prescaler.sv
// Programmable divider producing a one-cycle tick every (div+1) enabled cycles.
// The tick is combinational so mtime advances at the end of the counter==div cycle.
module tick_prescaler #(
  parameter int PRESCALE_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [PRESCALE_W-1:0] div,
  input  logic                  clr,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] cnt_reg;
  logic                  at_div;

  assign at_div = (cnt_reg == div);
  // A CTRL write restarts the count, so the old setting never produces a tick
  assign tick   = en && !clr && at_div;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (clr || !en || at_div) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/clint_timer.sv
// Shared 64-bit mtime with per-hart mtimecmp/mtip and msip, prescaled counting,
// atomic 64-bit writes through a write shadow and coherent reads through a read shadow.
module clint_timer
  import clint_pkg::*;
#(
  parameter int NUM_HARTS  = 2,
  parameter int PRESCALE_W = 8,
  parameter int ADDR_W     = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  input  logic                 req_write,
  input  logic [ADDR_W-1:0]    req_addr,
  input  logic [31:0]          req_wdata,
  output logic                 rsp_valid,
  output logic [31:0]          rsp_rdata,
  output logic                 rsp_err,
  output logic [NUM_HARTS-1:0] mtip,
  output logic [NUM_HARTS-1:0] msip
);

  generate
    if (NUM_HARTS < 1 || NUM_HARTS > 8) begin : g_bad_harts
      $error("clint_timer: NUM_HARTS must be 1..8");
    end
    if ((4 + 2 * NUM_HARTS) > (2 ** ADDR_W)) begin : g_bad_addr
      $error("clint_timer: ADDR_W too small for the register map");
    end
    if ((CTRL_DIV_LSB + PRESCALE_W) > 32) begin : g_bad_div
      $error("clint_timer: PRESCALE_W does not fit in CTRL");
    end
  endgenerate

  logic                  wr_en;
  logic                  rd_en;
  logic                  hit_mtime_lo;
  logic                  hit_mtime_hi;
  logic                  hit_ctrl;
  logic                  hit_msip;
  logic [NUM_HARTS-1:0]  hit_cmp_lo;
  logic [NUM_HARTS-1:0]  hit_cmp_hi;
  logic                  mapped;

  logic [63:0]           mtime_reg;
  logic [63:0]           mtime_next;
  logic [31:0]           wr_shadow_reg;
  logic [31:0]           rd_shadow_reg;
  logic                  en_reg;
  logic [PRESCALE_W-1:0] div_reg;
  logic [NUM_HARTS-1:0]  msip_reg;
  logic                  tick;

  logic                  rsp_valid_reg;
  logic [31:0]           rsp_rdata_reg;
  logic                  rsp_err_reg;
  logic [31:0]           rdata_next;

  logic [63:0]           cmp_val [NUM_HARTS];

  assign wr_en = req_valid && req_write;
  assign rd_en = req_valid && !req_write;

  assign hit_mtime_lo = (req_addr == ADDR_W'(ADDR_MTIME_LO));
  assign hit_mtime_hi = (req_addr == ADDR_W'(ADDR_MTIME_HI));
  assign hit_ctrl     = (req_addr == ADDR_W'(ADDR_CTRL));
  assign hit_msip     = (req_addr == ADDR_W'(ADDR_MSIP));
  assign mapped       = hit_mtime_lo || hit_mtime_hi || hit_ctrl || hit_msip
                        || (|hit_cmp_lo) || (|hit_cmp_hi);

  tick_prescaler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (en_reg),
    .div  (div_reg),
    .clr  (wr_en && hit_ctrl),
    .tick (tick)
  );

  // A committed mtime write wins over a tick in the same cycle
  always_comb begin
    mtime_next = mtime_reg;
    if (wr_en && hit_mtime_hi) begin
      mtime_next = {req_wdata, wr_shadow_reg};
    end else if (tick) begin
      mtime_next = mtime_reg + 64'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mtime_reg     <= '0;
      wr_shadow_reg <= '0;
      rd_shadow_reg <= '0;
      en_reg        <= 1'b0;
      div_reg       <= '0;
      msip_reg      <= '0;
    end else begin
      mtime_reg <= mtime_next;
      if (wr_en && (hit_mtime_lo || (|hit_cmp_lo))) begin
        wr_shadow_reg <= req_wdata;
      end
      if (rd_en && hit_mtime_lo) begin
        rd_shadow_reg <= mtime_reg[63:32];
      end
      if (wr_en && hit_ctrl) begin
        en_reg  <= req_wdata[CTRL_EN_BIT];
        div_reg <= req_wdata[CTRL_DIV_LSB +: PRESCALE_W];
      end
      if (wr_en && hit_msip) begin
        msip_reg <= req_wdata[NUM_HARTS-1:0];
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_HARTS; gi++) begin : g_hart
      logic [63:0] cmp_reg;
      logic        mtip_reg;

      assign hit_cmp_lo[gi] = (req_addr == ADDR_W'(cmp_addr(gi, 1'b0)));
      assign hit_cmp_hi[gi] = (req_addr == ADDR_W'(cmp_addr(gi, 1'b1)));

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cmp_reg  <= MTIMECMP_RESET;
          mtip_reg <= 1'b0;
        end else begin
          if (wr_en && hit_cmp_hi[gi]) begin
            cmp_reg <= {req_wdata, wr_shadow_reg};
          end
          mtip_reg <= (mtime_reg >= cmp_reg);
        end
      end

      assign cmp_val[gi] = cmp_reg;
      assign mtip[gi]    = mtip_reg;
    end
  endgenerate

  // MTIME_HI returns the snapshot taken by the last MTIME_LO read
  always_comb begin
    rdata_next = '0;
    if (rd_en) begin
      if (hit_mtime_lo) rdata_next = mtime_reg[31:0];
      if (hit_mtime_hi) rdata_next = rd_shadow_reg;
      if (hit_ctrl) begin
        rdata_next[CTRL_EN_BIT]                 = en_reg;
        rdata_next[CTRL_DIV_LSB +: PRESCALE_W]  = div_reg;
      end
      if (hit_msip) rdata_next[NUM_HARTS-1:0] = msip_reg;
      for (int h = 0; h < NUM_HARTS; h++) begin
        if (hit_cmp_lo[h]) rdata_next = cmp_val[h][31:0];
        if (hit_cmp_hi[h]) rdata_next = cmp_val[h][63:32];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_reg <= 1'b0;
      rsp_rdata_reg <= '0;
      rsp_err_reg   <= 1'b0;
    end else begin
      rsp_valid_reg <= req_valid;
      rsp_rdata_reg <= rdata_next;
      rsp_err_reg   <= req_valid && !mapped;
    end
  end

  assign rsp_valid = rsp_valid_reg;
  assign rsp_rdata = rsp_rdata_reg;
  assign rsp_err   = rsp_err_reg;
  assign msip      = msip_reg;

endmodule

// File: tb/tb_clint_timer.sv
// Self-checking bench for clint_timer: table-driven bus vectors plus hand-written
// timing sequences; responses are checked from a scoreboard queue at the falling edge.
module tb_clint_timer;

  localparam int NH = 2;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_addr  = '0;
  logic [31:0]   req_wdata = '0;
  logic          rsp_valid;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;
  logic [NH-1:0] mtip;
  logic [NH-1:0] msip;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        wr;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    string       name;
  } vec_t;

  typedef struct {
    logic        none;
    logic [31:0] rdata;
    logic        err;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  vec_t vecs[$];

  clint_timer #(
    .NUM_HARTS  (NH),
    .PRESCALE_W (8),
    .ADDR_W     (AW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .mtip      (mtip),
    .msip      (msip)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Response monitor: one scoreboard entry per request, popped at the falling edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        $display("rsp %s: valid=%0b rdata=0x%08h err=%0b", e.name, rsp_valid, rsp_rdata, rsp_err);
        if (e.none) begin
          check({e.name, " dropped"}, 64'(rsp_valid), 64'd0);
        end else begin
          check({e.name, " valid"}, 64'(rsp_valid), 64'd1);
          check({e.name, " rdata"}, 64'(rsp_rdata), 64'(e.rdata));
          check({e.name, " err"}, 64'(rsp_err), 64'(e.err));
        end
      end else if (rst === 1'b0) begin
        check("spurious rsp_valid", 64'(rsp_valid), 64'd0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic do_req(input logic wr, input logic [4:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_err, input string name);
    exp_t e;
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wdata;
    @(posedge clk);
    e.none  = 1'b0;
    e.rdata = exp_rdata;
    e.err   = exp_err;
    e.name  = name;
    sb_q.push_back(e);
    #1;
    req_valid = 1'b0;
    req_write = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic vec_t mk(input logic wr, input logic [4:0] addr, input logic [31:0] wdata,
                              input logic [31:0] exp_rdata, input logic exp_err, input string name);
    vec_t v;
    v.wr = wr; v.addr = addr; v.wdata = wdata;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.name = name;
    return v;
  endfunction

  task automatic run_vecs();
    foreach (vecs[i]) begin
      do_req(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata, vecs[i].exp_err, vecs[i].name);
    end
    vecs.delete();
  endtask

  initial begin
    int k;
    exp_t e;

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    idle(1);

    // Reset state
    check("reset mtip", 64'(mtip), 64'd0);
    check("reset msip", 64'(msip), 64'd0);
    vecs.push_back(mk(0, 0, 0, 32'h0, 0, "rst mtime_lo"));
    vecs.push_back(mk(0, 1, 0, 32'h0, 0, "rst mtime_hi"));
    vecs.push_back(mk(0, 2, 0, 32'h0, 0, "rst ctrl"));
    vecs.push_back(mk(0, 3, 0, 32'h0, 0, "rst msip"));
    vecs.push_back(mk(0, 4, 0, 32'hFFFF_FFFF, 0, "rst cmp0_lo"));
    vecs.push_back(mk(0, 5, 0, 32'hFFFF_FFFF, 0, "rst cmp0_hi"));
    vecs.push_back(mk(0, 6, 0, 32'hFFFF_FFFF, 0, "rst cmp1_lo"));
    vecs.push_back(mk(0, 7, 0, 32'hFFFF_FFFF, 0, "rst cmp1_hi"));
    run_vecs();
    idle(2);

    // Prescaler: DIV=3 ticks once per 4 cycles, 40 enabled cycles -> 10
    do_req(1, 2, 32'h0000_0301, 0, 0, "wr ctrl en div3");
    idle(40);
    do_req(1, 2, 32'h0000_0000, 0, 0, "wr ctrl disable");
    do_req(0, 0, 0, 32'd10, 0, "div3 mtime_lo");
    do_req(0, 1, 0, 32'd0, 0, "div3 mtime_hi");
    idle(20);
    do_req(0, 0, 0, 32'd10, 0, "disabled mtime_lo");

    // Atomic write across the 32-bit carry, then coherent read
    do_req(1, 0, 32'hFFFF_FFFE, 0, 0, "wr mtime_lo");
    do_req(1, 1, 32'h0000_0000, 0, 0, "wr mtime_hi");
    do_req(1, 2, 32'h0000_0001, 0, 0, "wr ctrl en div0");
    idle(3);
    do_req(0, 0, 0, 32'h0000_0001, 0, "carry mtime_lo");
    do_req(0, 1, 0, 32'h0000_0001, 0, "carry mtime_hi");
    do_req(1, 2, 32'h0000_0000, 0, 0, "wr ctrl disable");
    do_req(1, 0, 32'h0000_0000, 0, 0, "wr mtime_lo");
    do_req(1, 1, 32'h0000_0005, 0, 0, "wr mtime_hi 5");
    idle(5);
    do_req(0, 1, 0, 32'h0000_0001, 0, "stale shadow mtime_hi");
    do_req(0, 0, 0, 32'h0000_0000, 0, "fresh mtime_lo");
    do_req(0, 1, 0, 32'h0000_0005, 0, "fresh mtime_hi");

    // mtip[1] at compare value 20, counting from 0 at DIV=0
    do_req(1, 0, 32'h0, 0, 0, "wr mtime_lo");
    do_req(1, 1, 32'h0, 0, 0, "wr mtime_hi");
    do_req(1, 6, 32'd20, 0, 0, "wr cmp1_lo");
    do_req(1, 7, 32'd0, 0, 0, "wr cmp1_hi");
    idle(2);
    check("mtip before count", 64'(mtip), 64'd0);
    do_req(1, 2, 32'h0000_0001, 0, 0, "wr ctrl en div0");
    k = 1;
    while (!mtip[1] && k < 100) begin
      idle(1);
      k++;
    end
    check("mtip1 rise cycle", 64'(k), 64'd22);
    check("mtip0 stays low", 64'(mtip[0]), 64'd0);
    do_req(1, 6, 32'd100, 0, 0, "wr cmp1_lo 100");
    do_req(1, 7, 32'd0, 0, 0, "wr cmp1_hi");
    check("mtip1 still set at commit+1", 64'(mtip[1]), 64'd1);
    idle(1);
    check("mtip1 cleared", 64'(mtip[1]), 64'd0);
    do_req(1, 2, 32'h0000_0000, 0, 0, "wr ctrl disable");

    // LO half alone must not change the comparator
    do_req(1, 4, 32'h0000_0000, 0, 0, "wr cmp0_lo only");
    idle(2);
    check("mtip0 after lo only", 64'(mtip[0]), 64'd0);
    vecs.push_back(mk(0, 4, 0, 32'hFFFF_FFFF, 0, "cmp0_lo uncommitted"));
    vecs.push_back(mk(0, 5, 0, 32'hFFFF_FFFF, 0, "cmp0_hi uncommitted"));
    vecs.push_back(mk(1, 3, 32'hFFFF_FFFF, 0, 0, "wr msip all"));
    vecs.push_back(mk(0, 3, 0, 32'h0000_0003, 0, "rd msip"));
    vecs.push_back(mk(0, 31, 0, 32'h0, 1, "rd unmapped"));
    vecs.push_back(mk(1, 31, 32'h1234_5678, 32'h0, 1, "wr unmapped"));
    vecs.push_back(mk(0, 2, 0, 32'h0, 0, "rd ctrl"));
    run_vecs();
    check("msip pins", 64'(msip), 64'h3);

    // Set mtip[1] then reset while counting with a read in flight
    do_req(1, 6, 32'd0, 0, 0, "wr cmp1_lo 0");
    do_req(1, 7, 32'd0, 0, 0, "wr cmp1_hi 0");
    do_req(1, 2, 32'h0000_0001, 0, 0, "wr ctrl en div0");
    idle(2);
    check("mtip1 before reset", 64'(mtip[1]), 64'd1);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 5'd0;
    #2;
    rst = 1'b1;
    #1;
    check("async reset mtip", 64'(mtip), 64'd0);
    check("async reset msip", 64'(msip), 64'd0);
    check("async reset rsp_valid", 64'(rsp_valid), 64'd0);
    @(posedge clk);
    e.none = 1'b1; e.rdata = '0; e.err = 1'b0; e.name = "in-flight rd";
    sb_q.push_back(e);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    vecs.push_back(mk(0, 0, 0, 32'h0, 0, "post-rst mtime_lo"));
    vecs.push_back(mk(0, 1, 0, 32'h0, 0, "post-rst mtime_hi"));
    vecs.push_back(mk(0, 2, 0, 32'h0, 0, "post-rst ctrl"));
    vecs.push_back(mk(0, 6, 0, 32'hFFFF_FFFF, 0, "post-rst cmp1_lo"));
    vecs.push_back(mk(0, 7, 0, 32'hFFFF_FFFF, 0, "post-rst cmp1_hi"));
    run_vecs();
    idle(3);
    check("post-rst mtip", 64'(mtip), 64'd0);
    check("scoreboard drained", 64'(sb_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
